// File: rtl/octave_sample_ring.sv
// Per-octave sample window held in a single-port circular RAM.
// Exposes newest, second-newest and oldest samples plus the decimate-by-2 sum for the next octave.
module octave_sample_ring #(
  parameter int SIZE = 8192,
  parameter int N    = 16,
  parameter int AW   = $clog2(SIZE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] newSample,
  input  logic         writeSample,
  input  logic         flush,
  output logic         ready,
  output logic [N-1:0] sample0,
  output logic [N-1:0] sample1,
  output logic [N-1:0] oldestSample,
  output logic         dataValid,
  output logic [N:0]   nextOctave,
  output logic         nextValid,
  output logic [AW:0]  fillCount,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(SIZE);

  state_t        state;
  logic [AW-1:0] wp;
  logic          phase;
  logic [N-1:0]  rd_data;
  logic [N-1:0]  mem [SIZE];
  logic          accept;

  // Handshake: a write transfers on a rising edge where writeSample=1 and ready=1;
  // flush in the same cycle takes priority and the sample is dropped.
  assign accept     = (state == IDLE) && writeSample && !flush;
  assign ready      = (state == IDLE);
  assign state_dbg  = state;
  assign nextOctave = {sample0[N-1], sample0} + {sample1[N-1], sample1};

  // Single port: wp is the write address in IDLE and, once advanced, the oldest slot in RD.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wp] <= newSample;
    end
    rd_data <= mem[wp];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wp           <= '0;
      phase        <= 1'b0;
      sample0      <= '0;
      sample1      <= '0;
      oldestSample <= '0;
      dataValid    <= 1'b0;
      nextValid    <= 1'b0;
      fillCount    <= '0;
    end else if (flush) begin
      state        <= IDLE;
      wp           <= '0;
      phase        <= 1'b0;
      sample0      <= '0;
      sample1      <= '0;
      oldestSample <= '0;
      dataValid    <= 1'b0;
      nextValid    <= 1'b0;
      fillCount    <= '0;
    end else begin
      dataValid <= 1'b0;
      nextValid <= 1'b0;
      case (state)
        IDLE: begin
          if (writeSample) begin
            sample1 <= sample0;
            sample0 <= newSample;
            wp      <= wp + 1'b1;
            phase   <= ~phase;
            if (fillCount != FULL) begin
              fillCount <= fillCount + 1'b1;
            end
            state <= RD;
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          // Slots not yet written since reset/flush hold stale data; hide them until full.
          oldestSample <= (fillCount == FULL) ? rd_data : '0;
          dataValid    <= 1'b1;
          nextValid    <= (phase == 1'b0);
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_octave_sample_ring.sv
// Directed bench for octave_sample_ring with a 4-deep, 8-bit window.
module tb_octave_sample_ring;

  localparam int SIZE = 4;
  localparam int N    = 8;
  localparam int AW   = $clog2(SIZE);

  logic         clk;
  logic         rst;
  logic [N-1:0] newSample;
  logic         writeSample;
  logic         flush;
  logic         ready;
  logic [N-1:0] sample0;
  logic [N-1:0] sample1;
  logic [N-1:0] oldestSample;
  logic         dataValid;
  logic [N:0]   nextOctave;
  logic         nextValid;
  logic [AW:0]  fillCount;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  octave_sample_ring #(.SIZE(SIZE), .N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .newSample    (newSample),
    .writeSample  (writeSample),
    .flush        (flush),
    .ready        (ready),
    .sample0      (sample0),
    .sample1      (sample1),
    .oldestSample (oldestSample),
    .dataValid    (dataValid),
    .nextOctave   (nextOctave),
    .nextValid    (nextValid),
    .fillCount    (fillCount),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Full write transaction: accept, then check T+1, T+2 and T+3 (returns in T+3).
  task automatic do_write(input logic [N-1:0] v, input logic [N-1:0] exp_s1,
                          input logic [N-1:0] exp_old, input logic [AW:0] exp_fill,
                          input logic exp_nv, input logic [N:0] exp_oct);
    int budget;
    budget = 0;
    while (!ready && budget < 10) begin
      step();
      budget++;
    end
    chk("ready_before_write", {31'd0, ready}, 32'd1);
    newSample   = v;
    writeSample = 1'b1;
    step();
    writeSample = 1'b0;
    chk("s0_t1", {24'd0, sample0}, {24'd0, v});
    chk("s1_t1", {24'd0, sample1}, {24'd0, exp_s1});
    chk("fill_t1", {29'd0, fillCount}, {29'd0, exp_fill});
    chk("ready_t1", {31'd0, ready}, 32'd0);
    step();
    chk("ready_t2", {31'd0, ready}, 32'd0);
    chk("dv_t2", {31'd0, dataValid}, 32'd0);
    step();
    chk("dv_t3", {31'd0, dataValid}, 32'd1);
    chk("ready_t3", {31'd0, ready}, 32'd1);
    chk("oldest_t3", {24'd0, oldestSample}, {24'd0, exp_old});
    chk("nv_t3", {31'd0, nextValid}, {31'd0, exp_nv});
    if (exp_nv) chk("octave_t3", {23'd0, nextOctave}, {23'd0, exp_oct});
  endtask

  initial begin
    rst         = 1'b0;
    writeSample = 1'b0;
    flush       = 1'b0;
    newSample   = '0;

    // Reset
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_s0", {24'd0, sample0}, 32'd0);
    chk("rst_s1", {24'd0, sample1}, 32'd0);
    chk("rst_old", {24'd0, oldestSample}, 32'd0);
    chk("rst_nv", {31'd0, nextValid}, 32'd0);
    chk("rst_oct", {23'd0, nextOctave}, 32'd0);
    chk("rst_fill", {29'd0, fillCount}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk("rst_idle_dv", {31'd0, dataValid}, 32'd0);
      step();
    end

    // Fill and wrap at full rate
    do_write(8'd1, 8'd0, 8'd0, 3'd1, 1'b0, 9'd0);
    do_write(8'd2, 8'd1, 8'd0, 3'd2, 1'b1, 9'd3);
    do_write(8'd3, 8'd2, 8'd0, 3'd3, 1'b0, 9'd0);
    do_write(8'd4, 8'd3, 8'd1, 3'd4, 1'b1, 9'd7);
    do_write(8'd5, 8'd4, 8'd2, 3'd4, 1'b0, 9'd0);
    do_write(8'd6, 8'd5, 8'd3, 3'd4, 1'b1, 9'd11);
    chk("wrap_s1_final", {24'd0, sample1}, 32'd5);

    // Decimation with signed values
    do_flush();
    chk("flush_fill", {29'd0, fillCount}, 32'd0);
    do_write(8'd100, 8'd0,   8'd0,   3'd1, 1'b0, 9'd0);
    do_write(8'hEC,  8'd100, 8'd0,   3'd2, 1'b1, 9'd80);
    do_write(8'd127, 8'hEC,  8'd0,   3'd3, 1'b0, 9'd0);
    do_write(8'd127, 8'd127, 8'd100, 3'd4, 1'b1, 9'd254);

    // Handshake: writeSample held high, value changes every cycle
    do_flush();
    for (int c = 0; c < 9; c++) begin
      newSample   = 8'(7 + c);
      writeSample = 1'b1;
      step();
    end
    writeSample = 1'b0;
    step();
    step();
    chk("hs_fill", {29'd0, fillCount}, 32'd3);
    chk("hs_s0", {24'd0, sample0}, 32'd13);
    chk("hs_s1", {24'd0, sample1}, 32'd10);
    chk("hs_ready", {31'd0, ready}, 32'd1);

    // Flush during RD of the 5th write
    do_flush();
    do_write(8'd21, 8'd0,  8'd0, 3'd1, 1'b0, 9'd0);
    do_write(8'd22, 8'd21, 8'd0, 3'd2, 1'b1, 9'd43);
    do_write(8'd23, 8'd22, 8'd0, 3'd3, 1'b0, 9'd0);
    do_write(8'd24, 8'd23, 8'd21, 3'd4, 1'b1, 9'd47);
    newSample   = 8'd25;
    writeSample = 1'b1;
    step();
    writeSample = 1'b0;
    chk("fl_in_rd", {30'd0, state_dbg}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_state", {30'd0, state_dbg}, 32'd0);
    chk("fl_ready", {31'd0, ready}, 32'd1);
    chk("fl_s0", {24'd0, sample0}, 32'd0);
    chk("fl_s1", {24'd0, sample1}, 32'd0);
    chk("fl_old", {24'd0, oldestSample}, 32'd0);
    chk("fl_fill", {29'd0, fillCount}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("fl_no_dv", {31'd0, dataValid}, 32'd0);
      step();
    end
    do_write(8'd9, 8'd0, 8'd0, 3'd1, 1'b0, 9'd0);

    // Reset asserted in CAP
    newSample   = 8'd33;
    writeSample = 1'b1;
    step();
    writeSample = 1'b0;
    step();
    chk("rm_in_cap", {30'd0, state_dbg}, 32'd2);
    rst = 1'b0;
    #1;
    chk("rm_s0", {24'd0, sample0}, 32'd0);
    chk("rm_s1", {24'd0, sample1}, 32'd0);
    chk("rm_fill", {29'd0, fillCount}, 32'd0);
    chk("rm_ready", {31'd0, ready}, 32'd1);
    chk("rm_dv", {31'd0, dataValid}, 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rm_no_dv", {31'd0, dataValid}, 32'd0);
    end

    // writeSample together with flush in IDLE
    newSample   = 8'd55;
    writeSample = 1'b1;
    flush       = 1'b1;
    step();
    writeSample = 1'b0;
    flush       = 1'b0;
    chk("wf_fill", {29'd0, fillCount}, 32'd0);
    chk("wf_s0", {24'd0, sample0}, 32'd0);
    chk("wf_ready", {31'd0, ready}, 32'd1);
    step();
    chk("wf_state", {30'd0, state_dbg}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/octave_sample_ring.md
# octave_sample_ring

RAM-backed, parametrised successor to the per-octave shift-register sample storage of the sliding-DFT front end. It holds the last SIZE samples of one octave in a single-port circular RAM. It exposes the newest, second-newest and oldest samples to the bin-update loop, and produces the decimate-by-2 sum that feeds the next octave down. Compared with the shift-register storage, it adds a ready/valid write handshake, a fill counter, a synchronous flush, and zero-gating of the oldest sample until the window is full.

## Interface
- SIZE, 8192: window length in samples; power of two, ≥ 4.
- N, 16: sample width, signed.
- AW, $clog2(SIZE): RAM address width (derived; do not override).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- newSample  in  N  signed sample to store.
- writeSample  in  1  write request; accepted only in a cycle where ready=1.
- flush  in  1  synchronous clear of window state.
- ready  out  1  high only in IDLE.
- sample0  out  N  newest stored sample.
- sample1  out  N  second-newest stored sample.
- oldestSample  out  N  sample written SIZE-1 writes before sample0; 0 until the window is full.
- dataValid  out  1  1-cycle pulse: sample0/sample1/oldestSample are consistent for the latest write.
- nextOctave  out  N+1  sign-extended sample0 + sample1.
- nextValid  out  1  1-cycle pulse, coincident with dataValid on every second accepted write.
- fillCount  out  AW+1  number of writes since reset/flush, saturating at SIZE.

## Operation
- Storage: SIZE×N single-port RAM (one access per cycle, 1-cycle registered read), write pointer wp (AW bits, wraps naturally), phase bit for decimation.
- States: IDLE → RD → CAP → IDLE.
- IDLE, writeSample & !flush (accept):
  - mem[wp] ← newSample; sample1 ← sample0; sample0 ← newSample.
  - wp ← wp+1; fillCount ← min(fillCount+1, SIZE); phase toggles; go to RD.
- RD: present address wp (now pointing one past the newest sample, i.e. the oldest slot); go to CAP.
- CAP: oldestSample ← (fillCount == SIZE) ? RAM data : 0; dataValid ← 1 and nextValid ← (phase == 0) for the following cycle; go to IDLE.
- The first write sets phase to 1, so the first nextValid comes on the 2nd write; nextOctave at that point = s0+s1.
- nextOctave is combinational from sample0/sample1 and is meaningful only when nextValid = 1.
- flush (any state): next edge sets state=IDLE and clears sample0, sample1, oldestSample, wp, fillCount, phase, dataValid and nextValid. RAM contents are not cleared; fillCount gating makes them invisible.
- writeSample while ready=0: ignored, no side effect. writeSample together with flush: flush wins and the sample is dropped.
- Arithmetic: nextOctave = {sample0[N-1],sample0} + {sample1[N-1],sample1}; no overflow is possible.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, ready=1. All other outputs 0: sample0, sample1, oldestSample, dataValid, nextValid, nextOctave, fillCount.
- Accept in cycle T:
  - sample0, sample1 and fillCount are valid from T+1.
  - ready=0 in T+1 and T+2.
  - oldestSample is updated, and dataValid/nextValid are high, in T+3; ready=1 in T+3.
- Maximum throughput is 1 write per 3 cycles. A write may be accepted in T+3, the same cycle as dataValid.
- Window wrap: write k goes to address k mod SIZE. After write k ≥ SIZE-1, oldestSample = sample k-(SIZE-1).
- fillCount holds at SIZE after saturation; wp keeps wrapping.
- Reset asserted mid-operation (RD/CAP): immediate return to reset values; the pending dataValid is lost.

## Test plan
- Reset: SIZE=4, N=8; hold rst=0 for 2 cycles, release -> ready=1, every other output 0, no dataValid for 10 idle cycles.
- Fill and wrap: write 1,2,3,4,5,6 back-to-back at full rate -> dataValid every 3 cycles. oldestSample reads 0,0,0,1,2,3. fillCount reads 1,2,3,4,4,4. sample1 after the 6th write = 5.
- Decimation: write 100,-20,127,127 -> nextValid on writes 2 and 4 only, with nextOctave=80 and then 254 (9-bit, no wrap).
- Handshake: hold writeSample high continuously with values 7,8,9,... -> only the samples present in cycles with ready=1 are stored; no double writes.
- Flush: after 5 writes, assert flush during RD -> next cycle IDLE, outputs 0, no dataValid. Write 9 -> sample0=9, oldestSample=0, fillCount=1.
- Reset mid-op and simultaneous events:
  - Assert rst in CAP -> outputs 0 immediately.
  - writeSample together with flush in IDLE -> fillCount stays 0, sample0=0.
